// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM with variable-latency memory handshake and retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap on illegal encodings (adds the illegal port); otherwise they retire as NOPs.
module mc_control_unit #(
    parameter int ALUCTRL_W = 4,
    parameter int IMMSRC_W  = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 Zero,
    input  logic                 Less,
    input  logic                 LessU,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUctrl,
    output logic [IMMSRC_W-1:0]  ImmSrc,
    output logic [1:0]           ResultSrc,
    output logic                 RegWrite,
    output logic [2:0]           funct3O,
    output logic                 retire,
    output logic [CNT_W-1:0]     retired_cnt,
    output logic [3:0]           state_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                 illegal
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADDR  = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JALR     = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_UPPER    = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD   = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB   = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR   = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR    = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_AND   = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL   = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL   = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA   = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT   = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU  = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(10);

    localparam logic [IMMSRC_W-1:0] IMM_I  = IMMSRC_W'(0);
    localparam logic [IMMSRC_W-1:0] IMM_IU = IMMSRC_W'(1);
    localparam logic [IMMSRC_W-1:0] IMM_S  = IMMSRC_W'(2);
    localparam logic [IMMSRC_W-1:0] IMM_B  = IMMSRC_W'(3);
    localparam logic [IMMSRC_W-1:0] IMM_U  = IMMSRC_W'(4);
    localparam logic [IMMSRC_W-1:0] IMM_J  = IMMSRC_W'(5);

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_4     = 2'b10;

    logic [3:0] state;
    logic [3:0] state_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       r_f7_ok;
    logic       i_f7_ok;
    logic       bad_instr;
    logic       take;
    logic       unused_instr_bits;

    assign op      = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign funct3O = f3;
    assign state_o = state;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    function automatic logic [ALUCTRL_W-1:0] alu_dec(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // funct7 is only an opcode extension for R-type and the I-type shifts; elsewhere it is immediate.
    always_comb begin
        r_f7_ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        i_f7_ok = 1'b1;
        if (f3 == 3'b001)
            i_f7_ok = (f7 == 7'h00);
        else if (f3 == 3'b101)
            i_f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
        case (op)
            OP_LOAD, OP_STORE, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: bad_instr = 1'b0;
            OP_R:    bad_instr = !r_f7_ok;
            OP_I:    bad_instr = !i_f7_ok;
            default: bad_instr = 1'b1;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  take = Zero;
            3'b001:  take = !Zero;
            3'b100:  take = Less;
            3'b101:  take = !Less;
            3'b110:  take = LessU;
            3'b111:  take = !LessU;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:   if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                if (bad_instr) begin
`ifdef ILLEGAL_TRAP_EN
                    state_n = S_TRAP;
`else
                    state_n = S_FETCH;
`endif
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_n = S_MEMADDR;
                        OP_R:              state_n = S_EXEC_R;
                        OP_I:              state_n = S_EXEC_I;
                        OP_B:              state_n = S_BRANCH;
                        OP_JAL:            state_n = S_JUMP;
                        OP_JALR:           state_n = S_JALR;
                        OP_LUI, OP_AUIPC:  state_n = S_UPPER;
                        default:           state_n = S_FETCH;
                    endcase
                end
            end
            S_MEMADDR:  state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_n = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_n = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_UPPER: state_n = S_ALUWB;
            S_JALR:     state_n = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_n = S_TRAP;
`endif
            default:    state_n = S_FETCH;
        endcase
    end

    // Every control is forced low while rst is high so an in-flight memory request drops at once.
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUctrl   = ALU_ADD;
        ImmSrc    = IMM_I;
        ResultSrc = 2'b00;
        RegWrite  = 1'b0;
        retire    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = SRCB_4;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
`ifndef ILLEGAL_TRAP_EN
                    retire  = bad_instr;
`endif
                end
                S_MEMADDR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    retire   = mem_ready;
                end
                S_EXEC_R: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    ALUctrl = alu_dec(f3, f7[5]);
                end
                S_EXEC_I: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = ((f3 == 3'b001) || (f3 == 3'b101) || (f3 == 3'b011)) ? IMM_IU : IMM_I;
                    ALUctrl = alu_dec(f3, f7[5] && (f3 == 3'b101));
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    ALUctrl = ALU_SUB;
                    PCSrc   = 1'b1;
                    PCWrite = take;
                    retire  = 1'b1;
                end
                S_JALR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_JUMP: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_4;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                    PCWrite   = 1'b1;
                    PCSrc     = 1'b1;
                    retire    = 1'b1;
                end
                S_UPPER: begin
                    ImmSrc  = IMM_U;
                    ALUSrcB = SRCB_IMM;
                    ALUSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                    ALUctrl = (op == OP_LUI) ? ALU_PASSB : ALU_ADD;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = !rst && (state == S_TRAP);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            retired_cnt <= '0;
        end else begin
            state <= state_n;
            if (retire)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule
